// File: rtl/reg_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_sel_pkg
//  Brief    : Shared sizing constants and FSM state type for reg_select_decoder
//  Revision : 1.0 - initial release
// ============================================================================
package reg_sel_pkg;

    localparam int ADDR_W = 5;
    localparam int N_OUT  = 1 << ADDR_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_decode.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_decode
//  Brief    : Combinational binary-to-one-hot decoder with enable
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_decode #(
    parameter int ADDR_W = 5,
    parameter int N_OUT  = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [N_OUT-1:0]  onehot
);

    genvar i;
    generate
        for (i = 0; i < N_OUT; i++) begin : g_bit
            assign onehot[i] = en && (addr == ADDR_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_select_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : reg_select_decoder
//  Brief    : Registered one-hot register-file write select with clear sweep
//  Revision : 1.0 - initial release
// ============================================================================
module reg_select_decoder #(
    parameter int ADDR_W    = reg_sel_pkg::ADDR_W,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [ADDR_W-1:0]       wr_addr,
    output logic                    wr_ready,
    input  logic                    clr_start,
    output logic [(1<<ADDR_W)-1:0]  sel,
    output logic [ADDR_W-1:0]       sel_addr,
    output logic                    sel_valid,
    output logic                    busy,
    output logic                    clr_done
);

    import reg_sel_pkg::state_t;
    import reg_sel_pkg::IDLE;
    import reg_sel_pkg::SWEEP;

    localparam int               N_OUT       = 1 << ADDR_W;
    // idx carries one extra bit so the terminal compare cannot alias
    localparam logic [ADDR_W:0]  c_first_idx = (ADDR_W+1)'(SKIP_ZERO);
    localparam logic [ADDR_W:0]  c_last_idx  = (ADDR_W+1)'(N_OUT - 1);
    localparam logic [ADDR_W:0]  c_idx_one   = (ADDR_W+1)'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W:0]    r_idx;
    logic [ADDR_W:0]    w_idx_next;
    logic               w_clr_done_next;
    logic               w_sweep_next;
    logic               w_wr_fire;
    logic               w_wr_drop;
    logic [ADDR_W-1:0]  w_dec_addr;
    logic               w_dec_en;
    logic [N_OUT-1:0]   w_dec_sel;
    logic [ADDR_W-1:0]  w_sel_addr_next;
    logic               w_sel_valid_next;

    logic [N_OUT-1:0]   r_sel;
    logic [ADDR_W-1:0]  r_sel_addr;
    logic               r_sel_valid;
    logic               r_busy;
    logic               r_clr_done;

    // Gated by rst_n so nothing appears accepted while the block is held in reset
    assign wr_ready  = rst_n & (r_state == IDLE) & ~clr_start;
    assign w_wr_fire = wr_valid & wr_ready;
    assign w_wr_drop = SKIP_ZERO && (wr_addr == '0);

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_clr_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (clr_start) begin
                    w_state_next = SWEEP;
                    w_idx_next   = c_first_idx;
                end
            end
            SWEEP: begin
                if (r_idx == c_last_idx) begin
                    w_state_next    = IDLE;
                    w_clr_done_next = 1'b1;
                end else begin
                    w_idx_next = r_idx + c_idx_one;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output registers are loaded with the select for the index about to be held
    assign w_sweep_next     = (w_state_next == SWEEP);
    assign w_dec_addr       = w_sweep_next ? w_idx_next[ADDR_W-1:0] : wr_addr;
    assign w_dec_en         = w_sweep_next | (w_wr_fire & ~w_wr_drop);
    assign w_sel_addr_next  = w_dec_en ? w_dec_addr : '0;
    assign w_sel_valid_next = w_sweep_next | w_wr_fire;

    onehot_decode #(
        .ADDR_W (ADDR_W),
        .N_OUT  (N_OUT)
    ) u_decode (
        .addr   (w_dec_addr),
        .en     (w_dec_en),
        .onehot (w_dec_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_sel       <= '0;
            r_sel_addr  <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_sel       <= w_dec_sel;
            r_sel_addr  <= w_sel_addr_next;
            r_sel_valid <= w_sel_valid_next;
            r_busy      <= w_sweep_next;
            r_clr_done  <= w_clr_done_next;
        end
    end

    assign sel       = r_sel;
    assign sel_addr  = r_sel_addr;
    assign sel_valid = r_sel_valid;
    assign busy      = r_busy;
    assign clr_done  = r_clr_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_select_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_select_decoder
//  Brief    : Directed self-checking bench for reg_select_decoder
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_select_decoder;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic        wr_ready;
    logic        clr_start;
    logic [31:0] sel;
    logic [4:0]  sel_addr;
    logic        sel_valid;
    logic        busy;
    logic        clr_done;

    int          total = 0;
    int          bad   = 0;
    logic        inv_ok;

    reg_select_decoder #(
        .ADDR_W    (5),
        .SKIP_ZERO (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_ready  (wr_ready),
        .clr_start (clr_start),
        .sel       (sel),
        .sel_addr  (sel_addr),
        .sel_valid (sel_valid),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sel"},   sel, 32'h0);
        check({tag, "_addr"},  32'(sel_addr), 32'd0);
        check({tag, "_valid"}, 32'(sel_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(clr_done), 32'd0);
    endtask

    // Checks sweep selects from index 'first' to 31, then the done pulse
    task automatic sweep_rest(input int first);
        logic [31:0] exp_sel;
        for (int k = first; k < 32; k++) begin
            tick();
            exp_sel = 32'h1 << k;
            check("sweep_sel",   sel, exp_sel);
            check("sweep_addr",  32'(sel_addr), 32'(k));
            check("sweep_busy",  32'(busy), 32'd1);
            check("sweep_ready", 32'(wr_ready), 32'd0);
            if (k == 31) begin
                wr_valid  = 1'b0;
                clr_start = 1'b0;
            end
        end
        tick();
        check("done_pulse", 32'(clr_done), 32'd1);
        check("done_busy",  32'(busy), 32'd0);
        check("done_sel",   sel, 32'h0);
        check("done_valid", 32'(sel_valid), 32'd0);
        check("done_ready", 32'(wr_ready), 32'd1);
        tick();
        check("done_once",  32'(clr_done), 32'd0);
    endtask

    always @(negedge clk) begin
        inv_ok = $onehot0(sel)
               && (sel_valid || (sel == 32'h0))
               && ((sel == 32'h0) ? (sel_addr == 5'd0) : (sel == (32'h1 << sel_addr)))
               && !(busy && wr_ready);
        check("invariant", 32'(inv_ok), 32'd1);
    end

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = 5'd0;
        clr_start = 1'b0;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            wr_valid  = 1'b1;
            wr_addr   = 5'(i + 5);
            clr_start = i[0];
            tick();
            check_idle("reset");
            check("reset_ready", 32'(wr_ready), 32'd0);
        end
        wr_valid  = 1'b0;
        clr_start = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("release_ready", 32'(wr_ready), 32'd1);
        tick();
        check_idle("post_reset");

        // Single write
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        tick();
        check("wr5_sel",   sel, 32'h0000_0020);
        check("wr5_addr",  32'(sel_addr), 32'd5);
        check("wr5_valid", 32'(sel_valid), 32'd1);
        wr_valid = 1'b0;
        tick();
        check("wr5_after_sel",   sel, 32'h0);
        check("wr5_after_valid", 32'(sel_valid), 32'd0);

        // Back-to-back writes, including the hardwired register 0
        wr_valid = 1'b1;
        wr_addr  = 5'd31;
        tick();
        check("b2b31_sel",   sel, 32'h8000_0000);
        check("b2b31_addr",  32'(sel_addr), 32'd31);
        check("b2b31_valid", 32'(sel_valid), 32'd1);
        wr_addr = 5'd0;
        tick();
        check("b2b0_sel",   sel, 32'h0);
        check("b2b0_addr",  32'(sel_addr), 32'd0);
        check("b2b0_valid", 32'(sel_valid), 32'd1);
        wr_addr = 5'd1;
        tick();
        check("b2b1_sel",   sel, 32'h0000_0002);
        check("b2b1_addr",  32'(sel_addr), 32'd1);
        check("b2b1_valid", 32'(sel_valid), 32'd1);
        wr_valid = 1'b0;
        tick();
        check("b2b_end_valid", 32'(sel_valid), 32'd0);

        // Full sweep; writes and a second clr_start during it are ignored
        clr_start = 1'b1;
        #1;
        check("clr_ready", 32'(wr_ready), 32'd0);
        tick();
        check("clr_busy",  32'(busy), 32'd1);
        check("clr_ready2", 32'(wr_ready), 32'd0);
        check("clr_sel",   sel, 32'h0000_0002);
        check("clr_addr",  32'(sel_addr), 32'd1);
        wr_valid = 1'b1;
        wr_addr  = 5'd3;
        sweep_rest(2);

        // Clear wins over a simultaneous write
        clr_start = 1'b1;
        wr_valid  = 1'b1;
        wr_addr   = 5'd7;
        #1;
        check("clash_ready", 32'(wr_ready), 32'd0);
        tick();
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        check("clash_sel",  sel, 32'h0000_0002);
        check("clash_busy", 32'(busy), 32'd1);
        sweep_rest(2);

        // Reset in the middle of a sweep
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("mid_first", 32'(sel_addr), 32'd1);
        repeat (9) tick();
        check("mid_addr10", 32'(sel_addr), 32'd10);
        check("mid_sel10",  sel, 32'h0000_0400);
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        tick();
        tick();
        check_idle("mid_reset_hold");
        rst_n = 1'b1;
        tick();
        check_idle("mid_release");
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        check("restart_sel",  sel, 32'h0000_0002);
        check("restart_busy", 32'(busy), 32'd1);
        sweep_rest(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
